// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, FIFO entry layout and write-source encoding for the WB port arbiter.
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } mdu_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_MDU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO of queued MDU results. Exposes per-entry valid/dest so the
// arbiter can flag RAW hazards against any queued destination.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  mdu_entry_t                         push_entry,
    input  logic                               pop,
    output mdu_entry_t                         head,
    output logic                               full,
    output logic                               empty,
    output logic [DEPTH-1:0]                   entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]   entry_dest
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    mdu_entry_t      mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PW-1:0] offset;
        assign offset         = PW'(i) - rd_ptr;
        assign entry_valid[i] = ({1'b0, offset} < count);
        assign entry_dest[i]  = mem[i].dest;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and queued MDU
// results; pipeline writes win, MDU results drain in idle slots.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_reg_write,
    input  logic                  wb_mem_to_reg,
    input  logic [DATA_W-1:0]     wb_read_data,
    input  logic [DATA_W-1:0]     wb_alu_result,
    input  logic [REG_ADDR_W-1:0] wb_write_register,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_dest,
    input  logic [DATA_W-1:0]     mdu_result,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic                  rs_pending,
    output logic                  rt_pending,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  stall_req
);

    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);

    logic                               pipe_wr;
    logic                               fifo_push;
    logic                               fifo_pop;
    logic                               fifo_full;
    logic                               fifo_empty;
    mdu_entry_t                         fifo_head;
    logic [DEPTH-1:0]                   entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]   entry_dest;
    logic [AW-1:0]                      age;
    wb_src_e                            src;
    logic                               rs_hit;
    logic                               rt_hit;

    assign pipe_wr   = wb_reg_write && (wb_write_register != REG_ZERO);
    assign mdu_ready = !fifo_full;
    // A result for $0 is handshaked away but never occupies a slot.
    assign fifo_push = mdu_valid && mdu_ready && (mdu_dest != REG_ZERO);
    assign fifo_pop  = !pipe_wr && !fifo_empty;

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifo_push),
        .push_entry  ('{dest: mdu_dest, data: mdu_result}),
        .pop         (fifo_pop),
        .head        (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_dest  (entry_dest)
    );

    always_comb begin
        src = SRC_NONE;
        if (!rst_n)           src = SRC_NONE;
        else if (pipe_wr)     src = SRC_PIPE;
        else if (!fifo_empty) src = SRC_MDU;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = REG_ZERO;
        rf_wdata = '0;
        case (src)
            SRC_PIPE: begin
                rf_we    = 1'b1;
                rf_waddr = wb_write_register;
                rf_wdata = wb_mem_to_reg ? wb_read_data : wb_alu_result;
            end
            SRC_MDU: begin
                rf_we    = 1'b1;
                rf_waddr = fifo_head.dest;
                rf_wdata = fifo_head.data;
            end
            default: ;
        endcase
    end

    // Age measures how long the current head has been waiting for a free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     age <= '0;
        else if (fifo_empty || fifo_pop) age <= '0;
        else if (age != AGE_MAX)         age <= age + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              stall_req <= 1'b0;
        else if (fifo_pop)       stall_req <= 1'b0;
        else if (age == AGE_MAX) stall_req <= 1'b1;
    end

    // Includes the head even in the cycle it drains, since the write lands at the edge.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_dest[i] == rs_addr)) rs_hit = 1'b1;
            if (entry_valid[i] && (entry_dest[i] == rt_addr)) rt_hit = 1'b1;
        end
    end

    assign rs_pending = rst_n && (rs_addr != REG_ZERO) && rs_hit;
    assign rt_pending = rst_n && (rt_addr != REG_ZERO) && rt_hit;

endmodule
